// File: rtl/dmem_loader_pkg.sv
// Shared types and constants for the data-memory boot loader.
package dmem_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2,
        ST_RUN  = 2'd3
    } state_e;

    localparam int unsigned WORD_STRIDE = 4;

    function automatic logic word_aligned(input logic [1:0] low_bits);
        return low_bits == 2'b00;
    endfunction

endpackage

// File: rtl/dmem_loader_release_counter.sv
// Loadable down-counter that times the CPU release delay.
module release_counter #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/dmem_loader.sv
// Streams words into data memory and holds the CPU in reset until the image is loaded.
module dmem_loader
    import dmem_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = 12,
    parameter int unsigned DEPTH         = 1024,
    parameter int unsigned RELEASE_DELAY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [15:0]           word_count,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [31:0]           s_data,
    input  logic                  s_last,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_reset,
    output logic                  done,
    output logic                  err
);

    localparam int unsigned CNT_W = (RELEASE_DELAY < 1) ? 1 : $clog2(RELEASE_DELAY + 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [15:0]           rem_q, rem_d;
    logic                  err_q, err_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  cpu_reset_q, cpu_reset_d;
    logic                  done_q, done_d;
    logic                  cnt_load, cnt_dec, cnt_zero;
    logic                  req_bad;
    logic                  final_beat;

    release_counter #(
        .WIDTH(CNT_W)
    ) u_release_counter (
        .clk        (clk),
        .reset      (reset),
        .load_i     (cnt_load),
        .load_val_i (CNT_W'(RELEASE_DELAY)),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    assign req_bad    = !word_aligned(base_addr[1:0]) || ({1'b0, word_count} > 17'(DEPTH));
    assign final_beat = (rem_q == 16'd1);

    // The counter is loaded with the full delay on HOLD entry and RUN is taken
    // only once it reads zero, so release lands RELEASE_DELAY+1 edges after entry.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        rem_d    = rem_q;
        err_d    = err_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;

        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (start) begin
                    if (req_bad) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        err_d = 1'b0;
                        ptr_d = base_addr;
                        rem_d = word_count;
                        if (word_count == 16'd0) begin
                            state_d  = ST_HOLD;
                            cnt_load = 1'b1;
                        end else begin
                            state_d = ST_LOAD;
                        end
                    end
                end
            end
            ST_LOAD: begin
                if (s_valid) begin
                    we_d    = 1'b1;
                    addr_d  = ptr_q;
                    wdata_d = s_data;
                    ptr_d   = ptr_q + ADDR_WIDTH'(WORD_STRIDE);
                    rem_d   = rem_q - 16'd1;
                    if (s_last != final_beat) begin
                        err_d = 1'b1;
                    end
                    if (final_beat) begin
                        state_d  = ST_HOLD;
                        cnt_load = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (cnt_zero) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        cpu_reset_d = (state_d != ST_RUN);
        done_d      = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            rem_q       <= '0;
            err_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            rem_q       <= rem_d;
            err_q       <= err_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_reset_q <= cpu_reset_d;
            done_q      <= done_d;
        end
    end

    assign s_ready   = (state_q == ST_LOAD);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_reset = cpu_reset_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_dmem_loader.sv
// Directed self-checking bench for dmem_loader (ADDR_WIDTH=12, DEPTH=1024, RELEASE_DELAY=2).
module tb_dmem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [11:0] base_addr = '0;
    logic [15:0] word_count = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_data = '0;
    logic        s_last = 1'b0;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_reset;
    logic        done;
    logic        err;

    int checks = 0;
    int failures = 0;

    logic [31:0] tb_mem [0:1023];
    int          wr_count = 0;

    dmem_loader #(
        .ADDR_WIDTH    (12),
        .DEPTH         (1024),
        .RELEASE_DELAY (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we === 1'b1) begin
            tb_mem[mem_addr[11:2]] = mem_wdata;
            wr_count++;
        end
    end

    task tick;
        @(posedge clk);
        #1;
    endtask

    task test_reset;
        repeat (3) tick;
        checks++;
        if (cpu_reset !== 1'b1 || s_ready !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 12'h000 ||
            mem_wdata !== 32'h0 || done !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL reset_state act cpu_reset=%b s_ready=%b we=%b addr=%h wdata=%h done=%b err=%b req 1,0,0,000,0,0,0",
                     cpu_reset, s_ready, mem_we, mem_addr, mem_wdata, done, err);
        end
        reset = 1'b0;
        tick;
    endtask

    task test_basic_load;
        int w0;
        w0 = wr_count;
        start = 1'b1; base_addr = 12'h000; word_count = 16'd8;
        s_valid = 1'b1; s_data = 32'd1; s_last = 1'b0;
        tick;
        start = 1'b0;
        checks++;
        if (s_ready !== 1'b1) begin
            failures++; $display("FAIL basic_ready act=%b req=1", s_ready);
        end
        for (int k = 1; k <= 8; k++) begin
            s_data = 32'(k); s_last = (k == 8);
            tick;
            checks++;
            if (mem_we !== 1'b1 || mem_addr !== 12'(4 * (k - 1)) || mem_wdata !== 32'(k)) begin
                failures++;
                $display("FAIL basic_write%0d act we=%b addr=%h data=%h req we=1 addr=%h data=%h",
                         k, mem_we, mem_addr, mem_wdata, 12'(4 * (k - 1)), 32'(k));
            end
        end
        s_valid = 1'b0; s_last = 1'b0;
        tick;
        checks++;
        if (mem_we !== 1'b0 || cpu_reset !== 1'b1 || s_ready !== 1'b0) begin
            failures++; $display("FAIL basic_hold1 act we=%b cpu_reset=%b s_ready=%b req 0,1,0", mem_we, cpu_reset, s_ready);
        end
        tick;
        checks++;
        if (cpu_reset !== 1'b1 || done !== 1'b0) begin
            failures++; $display("FAIL basic_hold2 act cpu_reset=%b done=%b req 1,0", cpu_reset, done);
        end
        tick;
        checks++;
        if (cpu_reset !== 1'b0 || done !== 1'b1 || err !== 1'b0) begin
            failures++; $display("FAIL basic_release act cpu_reset=%b done=%b err=%b req 0,1,0", cpu_reset, done, err);
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (tb_mem[k] !== 32'(k + 1)) begin
                failures++; $display("FAIL basic_image%0d act=%h req=%h", k, tb_mem[k], 32'(k + 1));
            end
        end
        checks++;
        if (wr_count - w0 != 8) begin
            failures++; $display("FAIL basic_wrcount act=%0d req=8", wr_count - w0);
        end
    endtask

    task test_stall_load;
        start = 1'b1; base_addr = 12'h100; word_count = 16'd8;
        s_valid = 1'b0; s_last = 1'b0;
        tick;
        start = 1'b0;
        checks++;
        if (cpu_reset !== 1'b1 || done !== 1'b0 || s_ready !== 1'b1) begin
            failures++; $display("FAIL stall_restart act cpu_reset=%b done=%b s_ready=%b req 1,0,1", cpu_reset, done, s_ready);
        end
        for (int k = 1; k <= 8; k++) begin
            s_valid = 1'b0; s_data = 32'hDEAD_BEEF; s_last = 1'b1;
            tick;
            checks++;
            if (mem_we !== 1'b0) begin
                failures++; $display("FAIL stall_gap%0d act we=%b req 0", k, mem_we);
            end
            s_valid = 1'b1; s_data = 32'h10 + 32'(k); s_last = (k == 8);
            tick;
            checks++;
            if (mem_we !== 1'b1 || mem_addr !== 12'h100 + 12'(4 * (k - 1)) || mem_wdata !== 32'h10 + 32'(k)) begin
                failures++;
                $display("FAIL stall_write%0d act we=%b addr=%h data=%h req we=1 addr=%h data=%h",
                         k, mem_we, mem_addr, mem_wdata, 12'h100 + 12'(4 * (k - 1)), 32'h10 + 32'(k));
            end
        end
        s_valid = 1'b0; s_last = 1'b0;
        tick; tick;
        checks++;
        if (done !== 1'b0 || cpu_reset !== 1'b1) begin
            failures++; $display("FAIL stall_hold act done=%b cpu_reset=%b req 0,1", done, cpu_reset);
        end
        tick;
        checks++;
        if (done !== 1'b1 || cpu_reset !== 1'b0 || err !== 1'b0) begin
            failures++; $display("FAIL stall_release act done=%b cpu_reset=%b err=%b req 1,0,0", done, cpu_reset, err);
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (tb_mem[64 + k] !== 32'h11 + 32'(k)) begin
                failures++; $display("FAIL stall_image%0d act=%h req=%h", k, tb_mem[64 + k], 32'h11 + 32'(k));
            end
        end
    endtask

    task test_misaligned;
        int w0;
        w0 = wr_count;
        start = 1'b1; base_addr = 12'h006; word_count = 16'd4; s_valid = 1'b1; s_data = 32'h77;
        tick;
        start = 1'b0;
        checks++;
        if (err !== 1'b1 || cpu_reset !== 1'b1 || done !== 1'b0 || s_ready !== 1'b0) begin
            failures++; $display("FAIL misalign_reject act err=%b cpu_reset=%b done=%b s_ready=%b req 1,1,0,0", err, cpu_reset, done, s_ready);
        end
        tick; tick;
        checks++;
        if (wr_count != w0 || s_ready !== 1'b0 || err !== 1'b1) begin
            failures++; $display("FAIL misalign_idle act writes=%0d s_ready=%b err=%b req 0,0,1", wr_count - w0, s_ready, err);
        end
        start = 1'b1; base_addr = 12'h000; word_count = 16'd1;
        s_valid = 1'b1; s_data = 32'hAA; s_last = 1'b1;
        tick;
        start = 1'b0;
        checks++;
        if (err !== 1'b0 || s_ready !== 1'b1) begin
            failures++; $display("FAIL retry_clear act err=%b s_ready=%b req 0,1", err, s_ready);
        end
        tick;
        s_valid = 1'b0; s_last = 1'b0;
        tick; tick; tick;
        checks++;
        if (done !== 1'b1 || cpu_reset !== 1'b0 || tb_mem[0] !== 32'hAA) begin
            failures++; $display("FAIL retry_done act done=%b cpu_reset=%b mem0=%h req 1,0,000000aa", done, cpu_reset, tb_mem[0]);
        end
    endtask

    task test_overcount;
        start = 1'b1; base_addr = 12'h000; word_count = 16'd1025;
        tick;
        start = 1'b0;
        checks++;
        if (err !== 1'b1 || s_ready !== 1'b0 || cpu_reset !== 1'b1 || done !== 1'b0) begin
            failures++; $display("FAIL overcount act err=%b s_ready=%b cpu_reset=%b done=%b req 1,0,1,0", err, s_ready, cpu_reset, done);
        end
    endtask

    task test_last_mismatch;
        int w0;
        w0 = wr_count;
        start = 1'b1; base_addr = 12'h200; word_count = 16'd8; s_valid = 1'b1; s_last = 1'b0;
        tick;
        start = 1'b0;
        checks++;
        if (err !== 1'b0) begin
            failures++; $display("FAIL last_errclear act=%b req=0", err);
        end
        for (int k = 1; k <= 8; k++) begin
            s_data = 32'h50 + 32'(k); s_last = (k == 3);
            tick;
            if (k == 2) begin
                checks++;
                if (err !== 1'b0) begin
                    failures++; $display("FAIL last_before act=%b req=0", err);
                end
            end
            if (k == 3) begin
                checks++;
                if (err !== 1'b1) begin
                    failures++; $display("FAIL last_flag act=%b req=1", err);
                end
            end
        end
        s_valid = 1'b0; s_last = 1'b0;
        tick; tick; tick;
        checks++;
        if (wr_count - w0 != 8 || done !== 1'b1 || cpu_reset !== 1'b0 || err !== 1'b1 || tb_mem[135] !== 32'h58) begin
            failures++;
            $display("FAIL last_complete act writes=%0d done=%b cpu_reset=%b err=%b mem=%h req 8,1,0,1,00000058",
                     wr_count - w0, done, cpu_reset, err, tb_mem[135]);
        end
    endtask

    task test_zero_count;
        int w0;
        w0 = wr_count;
        start = 1'b1; base_addr = 12'h000; word_count = 16'd0;
        tick;
        start = 1'b0;
        checks++;
        if (cpu_reset !== 1'b1 || s_ready !== 1'b0 || err !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL zero_hold act cpu_reset=%b s_ready=%b err=%b done=%b req 1,0,0,0", cpu_reset, s_ready, err, done);
        end
        tick; tick;
        checks++;
        if (cpu_reset !== 1'b1) begin
            failures++; $display("FAIL zero_early act cpu_reset=%b req 1", cpu_reset);
        end
        tick;
        checks++;
        if (cpu_reset !== 1'b0 || done !== 1'b1 || wr_count != w0) begin
            failures++; $display("FAIL zero_release act cpu_reset=%b done=%b writes=%0d req 0,1,0", cpu_reset, done, wr_count - w0);
        end
    endtask

    task test_midload_reset;
        start = 1'b1; base_addr = 12'h300; word_count = 16'd8; s_valid = 1'b1; s_last = 1'b0;
        tick;
        start = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            s_data = 32'h30 + 32'(k);
            tick;
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (cpu_reset !== 1'b1 || s_ready !== 1'b0 || mem_we !== 1'b0 || done !== 1'b0 || err !== 1'b0 || mem_addr !== 12'h000) begin
            failures++;
            $display("FAIL async_reset act cpu_reset=%b s_ready=%b we=%b done=%b err=%b addr=%h req 1,0,0,0,0,000",
                     cpu_reset, s_ready, mem_we, done, err, mem_addr);
        end
        #2 reset = 1'b0;
        s_valid = 1'b0;
        tick;
        start = 1'b1; base_addr = 12'h300; word_count = 16'd8; s_valid = 1'b1; s_data = 32'h41;
        tick;
        start = 1'b0;
        checks++;
        if (s_ready !== 1'b1) begin
            failures++; $display("FAIL reload_ready act=%b req=1", s_ready);
        end
        for (int k = 1; k <= 8; k++) begin
            s_data = 32'h40 + 32'(k); s_last = (k == 8);
            tick;
        end
        s_valid = 1'b0; s_last = 1'b0;
        tick; tick;
        checks++;
        if (done !== 1'b0) begin
            failures++; $display("FAIL reload_early act done=%b req 0", done);
        end
        tick;
        checks++;
        if (done !== 1'b1 || cpu_reset !== 1'b0 || err !== 1'b0) begin
            failures++; $display("FAIL reload_release act done=%b cpu_reset=%b err=%b req 1,0,0", done, cpu_reset, err);
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (tb_mem[192 + k] !== 32'h41 + 32'(k)) begin
                failures++; $display("FAIL reload_image%0d act=%h req=%h", k, tb_mem[192 + k], 32'h41 + 32'(k));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout req=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 1024; i++) tb_mem[i] = '0;
        test_reset;
        test_basic_load;
        test_stall_load;
        test_misaligned;
        test_overcount;
        test_last_mismatch;
        test_zero_count;
        test_midload_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
